// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: buffers host command words and drives the display command bus, holding swaps until vblank start.
// Optional macro CMD_DISPATCH_AUTO_BUFFER_EN retargets bit 13 to the back buffer on issue.
module cmd_dispatcher #(
    parameter int FIFO_DEPTH  = 16,
    parameter int VBLANK_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_write,
    input  logic [31:0] host_writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        cmd_valid,
    output logic        host_full,
    output logic        overflow,
    output logic        front_buf,
    output logic        swap_pending
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {S_RUN, S_WAIT_VBL} state_t;
    state_t state_q, state_d;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    logic [31:0] cmd_q, cmd_d, head, issue;
    logic valid_q, valid_d, full_q, full_d, ovf_q, ovf_d, front_q, front_d, pend_q, pend_d, vbl_q;
    logic push, pop, head_swap, vbl, vbl_start;
    logic unused_hcount;

    assign unused_hcount = ^hcount;
    assign head = mem[rd_q];

    always_comb begin
        vbl = vcount == 10'(VBLANK_LINE);
        vbl_start = vbl & ~vbl_q;
        head_swap = head[20:17] == 4'b1111;
        // occupancy is judged at cycle start, so a same-cycle pop never makes room
        push = host_write && count_q < (AW+1)'(FIFO_DEPTH);
        pop = count_q != 0 && (state_q == S_RUN ? !head_swap : vbl_start);
        issue = head;
`ifdef CMD_DISPATCH_AUTO_BUFFER_EN
        issue[13] = ~front_q;
`endif
        state_d = state_q == S_RUN ? (count_q != 0 && head_swap ? S_WAIT_VBL : S_RUN)
                                   : (vbl_start ? S_RUN : S_WAIT_VBL);
        cmd_d = pop ? issue : 32'h0;
        valid_d = pop;
        front_d = pop && head_swap ? issue[13] : front_q;
        pend_d = state_d == S_WAIT_VBL;
        wr_d = wr_q + AW'(push);
        rd_d = rd_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        full_d = count_d == (AW+1)'(FIFO_DEPTH);
        ovf_d = ovf_q | (host_write & ~push);
    end

    always_ff @(posedge clk)
        if (push) mem[wr_q] <= host_writedata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cmd_q   <= 32'h0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            vbl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            vbl_q   <= vbl;
        end
    end

    assign cmd_out      = cmd_q;
    assign cmd_valid    = valid_q;
    assign host_full    = full_q;
    assign overflow     = ovf_q;
    assign front_buf    = front_q;
    assign swap_pending = pend_q;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed stimulus with a queue scoreboard of expected issued command words.
module tb_cmd_dispatcher;
    logic        clk, reset, host_write;
    logic [31:0] host_writedata;
    logic [9:0]  hcount, vcount;
    logic [31:0] cmd_out;
    logic        cmd_valid, host_full, overflow, front_buf, swap_pending;
    logic [31:0] sb [$];
    logic        mfb, fb_now;
    int          total, bad, nv;

    cmd_dispatcher dut (
        .clk(clk), .reset(reset), .host_write(host_write), .host_writedata(host_writedata),
        .hcount(hcount), .vcount(vcount), .cmd_out(cmd_out), .cmd_valid(cmd_valid),
        .host_full(host_full), .overflow(overflow), .front_buf(front_buf), .swap_pending(swap_pending)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) hcount <= hcount + 10'd1;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] xf(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef CMD_DISPATCH_AUTO_BUFFER_EN
        r[13] = ~mfb;
        if (w[20:17] == 4'hF) mfb = ~mfb;
`else
        if (w[20:17] == 4'hF) mfb = w[13];
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        if (cmd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_cmd observed=%h expected=none", cmd_out);
            end else begin
                e = sb.pop_front();
                chk("cmd_out", cmd_out, e);
                if (e[20:17] == 4'hF) fb_now = e[13];
            end
        end else chk("idle_out", cmd_out, 32'h0);
        chk("front_buf", {31'b0, front_buf}, {31'b0, fb_now});
    end

    task automatic wr(input logic [31:0] w);
        @(negedge clk);
        host_write = 1;
        host_writedata = w;
        if (sb.size() < 16) sb.push_back(xf(w));
    endtask

    task automatic idle();
        @(negedge clk);
        host_write = 0;
    endtask

    task automatic drain(input int n);
        int c;
        c = 0;
        while (sb.size() != 0 && c < n) begin
            @(negedge clk);
            c++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic vblank();
        @(negedge clk);
        vcount = 10'd480;
        @(negedge clk);
        vcount = 10'd0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; bad = 0; mfb = 0; fb_now = 0;
        reset = 0; host_write = 0; host_writedata = 0; hcount = 0; vcount = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_full", host_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_pend", swap_pending, 0);
        reset = 1;
        // single write latency
        wr(32'h0822_3005);
        idle();
        chk("t1_early", cmd_valid, 0);
        @(negedge clk);
        chk("t1_valid", cmd_valid, 1);
        chk("t1_out", cmd_out, 32'h0822_3005);
        @(negedge clk);
        chk("t1_after", cmd_valid, 0);
        // back-to-back updates
        wr(32'h0400_0001); chk("t2_full", host_full, 0);
        wr(32'h0420_0002); chk("t2_full", host_full, 0);
        wr(32'h0440_0003); chk("t2_v0", cmd_valid, 1);
        idle();            chk("t2_v1", cmd_valid, 1);
        @(negedge clk);    chk("t2_v2", cmd_valid, 1);
        @(negedge clk);    chk("t2_v3", cmd_valid, 0);
        chk("t2_full_end", host_full, 0);
        // swap held until vblank start
        vcount = 10'd100;
        wr(32'h001E_2000);
        wr(32'h0460_0004);
        idle();
        repeat (4) @(negedge clk);
        chk("t3_pend", swap_pending, 1);
        chk("t3_held", cmd_valid, 0);
        vcount = 10'd480;
        @(negedge clk);
        chk("t3_swap_valid", cmd_valid, 1);
        chk("t3_fb", front_buf, 1);
        chk("t3_pend_clr", swap_pending, 0);
        @(negedge clk);
        chk("t3_d_valid", cmd_valid, 1);
        repeat (3) @(negedge clk);
        vcount = 10'd0;
        drain(10);
        // overflow while a swap is stalled
        wr(32'h001E_2000);
        for (int i = 0; i < 16; i++) wr(32'h0500_0000 + i);
        idle();
        @(negedge clk);
        chk("t4_full", host_full, 1);
        chk("t4_ovf", overflow, 1);
        chk("t4_sb16", sb.size(), 16);
        vblank();
        drain(40);
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_full_clr", host_full, 0);
        // async reset while waiting for vblank
        wr(32'h001E_0000);
        for (int i = 0; i < 4; i++) wr(32'h0600_0000 + i);
        idle();
        repeat (3) @(negedge clk);
        chk("t5_pend", swap_pending, 1);
        #2;
        reset = 0;
        sb.delete();
        mfb = 0;
        fb_now = 0;
        #1;
        chk("t5_cmd_out", cmd_out, 0);
        chk("t5_valid", cmd_valid, 0);
        chk("t5_full", host_full, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_fb", front_buf, 0);
        chk("t5_pend0", swap_pending, 0);
        @(negedge clk);
        reset = 1;
        vblank();
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid) nv++;
        end
        chk("t5_nothing", nv, 0);
        // back-buffer targeting of update and swap
        wr(32'h0480_0005);
        wr(32'h001E_0000);
        idle();
        repeat (3) @(negedge clk);
        chk("t6_pend", swap_pending, 1);
        vblank();
        drain(10);
        chk("t6_fb", front_buf, mfb);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
- Sits directly upstream of the sprite/tile display components.
- Accepts 32-bit command words from the host-side Avalon write path and buffers them in a FIFO.
- Drives the shared command bus (component[31:26], child[25:21], action[20:17], action_type[16:14], buffer_toggle[13], action_data[12:0]) that every display component samples each clock.
- Issues normal update commands one per clock. Holds buffer-swap commands (action 4'b1111) until the start of vertical blanking, so page flips never tear.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of two, 4..64.
- VBLANK_LINE, 480, vcount value marking the first blanking line.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- host_write  in  1  host command strobe, one word per asserted cycle
- host_writedata  in  32  host command word
- hcount  in  10  current pixel column from VGA timing
- vcount  in  10  current line from VGA timing
- cmd_out  out  32  command bus to display components; 32'h0 = no-op
- cmd_valid  out  1  high for the single cycle cmd_out carries a command
- host_full  out  1  FIFO full; writes are dropped while high
- overflow  out  1  sticky; a write was dropped
- front_buf  out  1  buffer index currently displayed (last issued swap toggle)
- swap_pending  out  1  swap at FIFO head, waiting for vblank

Behaviour:
- Reset (reset==0, async):
  - FIFO emptied; state S_RUN.
  - cmd_out=0, cmd_valid=0, host_full=0, overflow=0, front_buf=0, swap_pending=0.
  - A reset mid-operation discards queued commands and any pending swap.
- FIFO:
  - Push when host_write && count<FIFO_DEPTH, using count at cycle start; a same-cycle pop does not free a slot for that write.
  - A write while full is dropped and sets overflow. overflow is cleared only by reset.
  - host_full = (count==FIFO_DEPTH), registered.
  - Pointers wrap modulo FIFO_DEPTH.
- Vblank detect:
  - vbl = (vcount==VBLANK_LINE); vbl_q is vbl registered.
  - vbl_start = vbl & ~vbl_q. This gives one pulse per frame regardless of hcount rate.
- Swap detect: head is a swap when head[20:17]==4'b1111.
- FSM:
  - S_RUN, FIFO non-empty, head not swap:
    - pop; cmd_out<=head; cmd_valid<=1.
  - S_RUN, head is swap:
    - no pop; cmd_out<=0; cmd_valid<=0; swap_pending<=1; go S_WAIT_VBL.
  - S_RUN, FIFO empty: cmd_out<=0; cmd_valid<=0.
  - S_WAIT_VBL:
    - cmd_out<=0 each cycle.
    - On vbl_start: pop; cmd_out<=head; cmd_valid<=1; front_buf<=head[13]; swap_pending<=0; go S_RUN.
    - If the swap reaches the head after vbl_start has already fired this frame, it waits for the next frame.
    - Commands behind the swap stay queued; order is strictly preserved.
- Latency: FIFO empty, state S_RUN, write sampled at edge k → cmd_out/cmd_valid asserted for exactly one cycle after edge k+1. Back-to-back writes issue back-to-back.
- Pushes continue during S_WAIT_VBL; only pops stall.
- No command word is modified except under the optional feature.

Optional Feature:
- Macro CMD_DISPATCH_AUTO_BUFFER_EN.
- Defined:
  - On issue, bit 13 of non-swap commands is overwritten with ~front_buf, so updates target the back buffer.
  - Swap commands are issued with bit 13 = ~front_buf, and front_buf toggles on issue.
  - Host bit 13 is ignored.
- Undefined: bit 13 passes through unchanged and front_buf takes the host-supplied bit 13.

Test Plan:
- Reset released, write 32'h0822_3005 at edge 5 → cmd_out=32'h0822_3005, cmd_valid=1 during the cycle after edge 6 only; cmd_out=0 afterwards.
- Write 3 updates back-to-back (A,B,C) → issued on 3 consecutive cycles in order A,B,C; host_full stays 0.
- Write swap 32'h001E_2000 then update D with vcount=100 → swap_pending=1, cmd_out=0, D held. vcount steps to 480 → swap issued on the cycle after the vbl_start edge and front_buf=1; D issued the next cycle.
- Write 17 words with FIFO_DEPTH=16 while a swap is stalled at the head → host_full=1 after 16 accepted; 17th dropped; overflow=1 and stays 1 until reset.
- Assert reset while in S_WAIT_VBL with 5 queued words → all outputs 0 immediately (async). After release and vblank, nothing is issued.
- With CMD_DISPATCH_AUTO_BUFFER_EN and front_buf=0, write an update with bit13=0 → issued with bit13=1. A following swap is issued with bit13=1 and front_buf becomes 1.
